// File: rtl/bc_turn_controller_if.sv
// Compare-datapath handshake between the turn controller and the bulls/cows datapath.
// Handshake: the master raises cmp_start for exactly one cycle and holds
// cmp_secret/cmp_guess stable from that cycle until the slave answers with a
// one-cycle cmp_done. cmp_bulls/cmp_cows are valid only in the cmp_done cycle.
// The master never issues a new cmp_start while a compare is outstanding.
interface bc_cmp_if;
   logic        cmp_start;
   logic [15:0] cmp_secret;
   logic [15:0] cmp_guess;
   logic        cmp_done;
   logic [2:0]  cmp_bulls;
   logic [2:0]  cmp_cows;

   modport master (
      output cmp_start, cmp_secret, cmp_guess,
      input  cmp_done, cmp_bulls, cmp_cows
   );

   modport slave (
      input  cmp_start, cmp_secret, cmp_guess,
      output cmp_done, cmp_bulls, cmp_cows
   );
endinterface

// File: rtl/bc_turn_controller.sv
// Bulls & Cows turn sequencer: debounces the confirm button, validates switch
// entries, runs the compare handshake and steps the two-player game FSM.
module bc_turn_controller #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DISP_CYCLES     = 200_000_000,
   parameter int ERR_CYCLES      = 50_000_000,
   parameter int MAX_ROUNDS      = 10
) (
   input  logic        clock,
   input  logic        CPU_RESETN,
   input  logic [15:0] SW,
   input  logic        confirm,
   bc_cmp_if.master    cmp,
   output logic [2:0]  state,
   output logic [2:0]  bulls,
   output logic [2:0]  cows,
   output logic        busy,
   output logic        err,
   output logic        winner,
   output logic [3:0]  round
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMR_W = $clog2(DISP_CYCLES + 1);
   localparam int ERR_W = $clog2(ERR_CYCLES + 1);

   typedef enum logic [2:0] {
      S_SECRET_J1 = 3'd0,
      S_SECRET_J2 = 3'd1,
      S_GUESS_J1  = 3'd2,
      S_GUESS_J2  = 3'd3,
      S_RESULT_J1 = 3'd4,
      S_RESULT_J2 = 3'd5,
      S_WIN       = 3'd6,
      S_FIM       = 3'd7
   } st_t;

   st_t              cur;
   logic             sync1, sync2, sync_prev;
   logic             deb_level;
   logic [DEB_W-1:0] deb_cnt;
   logic             press;
   logic [15:0]      secret1, secret2;
   logic [TMR_W-1:0] timer;
   logic [ERR_W-1:0] err_cnt;
   logic             entry_ok;

   // An entry is four BCD digits, all different from each other.
   function automatic logic entry_valid(input logic [15:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
         for (int j = i + 1; j < 4; j++) begin
            if (v[i*4 +: 4] == v[j*4 +: 4]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

   assign entry_ok = entry_valid(SW);
   assign state    = cur;

   // Synchronise the raw button, require a stable level, emit one pulse per accepted rising edge.
   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync_prev <= 1'b0;
         deb_level <= 1'b0;
         deb_cnt   <= '0;
         press     <= 1'b0;
      end else begin
         sync1     <= confirm;
         sync2     <= sync1;
         sync_prev <= sync2;
         press     <= 1'b0;
         if (sync2 != sync_prev) begin
            deb_cnt <= '0;
         end else if (sync2 != deb_level) begin
            if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_level <= sync2;
               press     <= sync2;
               deb_cnt   <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Game FSM with registered outputs, compare handshake and the display/err timers.
   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         cur            <= S_SECRET_J1;
         secret1        <= '0;
         secret2        <= '0;
         timer          <= '0;
         err_cnt        <= '0;
         err            <= 1'b0;
         busy           <= 1'b0;
         bulls          <= '0;
         cows           <= '0;
         winner         <= 1'b0;
         round          <= '0;
         cmp.cmp_start  <= 1'b0;
         cmp.cmp_secret <= '0;
         cmp.cmp_guess  <= '0;
      end else begin
         cmp.cmp_start <= 1'b0;
         if (err) begin
            if (err_cnt == '0) err <= 1'b0;
            else               err_cnt <= err_cnt - 1'b1;
         end
         case (cur)
            S_SECRET_J1, S_SECRET_J2: begin
               if (press) begin
                  if (entry_ok) begin
                     err <= 1'b0;
                     if (cur == S_SECRET_J1) begin
                        secret1 <= SW;
                        cur     <= S_SECRET_J2;
                     end else begin
                        secret2 <= SW;
                        cur     <= S_GUESS_J1;
                     end
                  end else begin
                     err     <= 1'b1;
                     err_cnt <= ERR_W'(ERR_CYCLES - 1);
                  end
               end
            end
            S_GUESS_J1, S_GUESS_J2: begin
               if (busy) begin
                  // The start cycle itself never counts as a completion.
                  if (!cmp.cmp_start && cmp.cmp_done) begin
                     bulls <= cmp.cmp_bulls;
                     cows  <= cmp.cmp_cows;
                     busy  <= 1'b0;
                     timer <= TMR_W'(DISP_CYCLES - 1);
                     if (cmp.cmp_bulls == 3'd4) begin
                        cur    <= S_WIN;
                        winner <= (cur == S_GUESS_J2);
                     end else begin
                        cur <= (cur == S_GUESS_J1) ? S_RESULT_J1 : S_RESULT_J2;
                     end
                  end
               end else if (press) begin
                  if (entry_ok) begin
                     err            <= 1'b0;
                     cmp.cmp_secret <= (cur == S_GUESS_J1) ? secret2 : secret1;
                     cmp.cmp_guess  <= SW;
                     cmp.cmp_start  <= 1'b1;
                     busy           <= 1'b1;
                  end else begin
                     err     <= 1'b1;
                     err_cnt <= ERR_W'(ERR_CYCLES - 1);
                  end
               end
            end
            S_RESULT_J1: begin
               if (timer == '0) cur <= S_GUESS_J2;
               else             timer <= timer - 1'b1;
            end
            S_RESULT_J2: begin
               if (timer == '0) begin
                  round <= round + 4'd1;
                  cur   <= ((round + 4'd1) == 4'(MAX_ROUNDS)) ? S_FIM : S_GUESS_J1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_WIN: begin
               if (timer == '0) cur <= S_FIM;
               else             timer <= timer - 1'b1;
            end
            S_FIM: begin
               cur <= S_FIM;
            end
            default: cur <= S_SECRET_J1;
         endcase
      end
   end

endmodule

// File: tb/tb_bc_turn_controller.sv
// Bench for bc_turn_controller: game-level reference model, a behavioural
// compare datapath and a scoreboard of expected {secret, guess} requests.
module tb_bc_turn_controller;

   localparam int DEB  = 200;
   localparam int DISP = 400;
   localparam int ERRC = 600;
   localparam int MAXR = 2;

   logic        clock = 1'b0;
   logic        CPU_RESETN;
   logic [15:0] SW;
   logic        confirm;
   logic [2:0]  state, bulls, cows;
   logic        busy, err, winner;
   logic [3:0]  round;

   bc_cmp_if cmp_if ();

   bc_turn_controller #(
      .DEBOUNCE_CYCLES(DEB), .DISP_CYCLES(DISP), .ERR_CYCLES(ERRC), .MAX_ROUNDS(MAXR)
   ) dut (
      .clock(clock), .CPU_RESETN(CPU_RESETN), .SW(SW), .confirm(confirm),
      .cmp(cmp_if), .state(state), .bulls(bulls), .cows(cows),
      .busy(busy), .err(err), .winner(winner), .round(round)
   );

   // clock / reset
   always #5 clock = ~clock;

   int          pass_cnt = 0, check_cnt = 0;
   int          resp_pass = 0, resp_checks = 0;
   int          start_cnt = 0;
   bit          resp_en = 1'b1;
   bit          inj_req = 1'b0;
   logic [31:0] exp_q[$];
   logic [15:0] m_s1, m_s2;

   // reference scoring: exact-position matches and misplaced matches
   function automatic void score(input logic [15:0] s, input logic [15:0] g,
                                 output logic [2:0] b, output logic [2:0] c);
      b = 0; c = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (s[i*4 +: 4] == g[j*4 +: 4]) begin
               if (i == j) b = b + 1;
               else        c = c + 1;
            end
   endfunction

   function automatic logic [15:0] rand_valid();
      int d[4];
      bit dup;
      do begin
         dup = 0;
         for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 9);
         for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
               if (d[i] == d[j]) dup = 1;
      end while (dup);
      return {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
   endfunction

   // behavioural compare datapath + scoreboard check of each request
   initial begin
      logic [15:0] sec, gss;
      logic [31:0] exp;
      logic [2:0]  b, c;
      bit          inj_prev, stable;
      int          d;
      inj_prev = 0;
      cmp_if.cmp_done  = 1'b0;
      cmp_if.cmp_bulls = '0;
      cmp_if.cmp_cows  = '0;
      forever begin
         @(negedge clock);
         if (inj_req && !inj_prev) begin
            cmp_if.cmp_bulls = 3'd4;
            cmp_if.cmp_cows  = 3'd0;
            cmp_if.cmp_done  = 1'b1;
            @(negedge clock);
            cmp_if.cmp_done  = 1'b0;
         end else if (cmp_if.cmp_start === 1'b1) begin
            start_cnt++;
            if (resp_en) begin
               sec = cmp_if.cmp_secret;
               gss = cmp_if.cmp_guess;
               resp_checks++;
               if (exp_q.size() == 0) begin
                  $display("FAIL cmp_request: got %h/%h, none expected", sec, gss);
               end else begin
                  exp = exp_q.pop_front();
                  if ({sec, gss} !== exp) $display("FAIL cmp_request: got %h want %h", {sec, gss}, exp);
                  else resp_pass++;
               end
               d = $urandom_range(3, 8);
               @(negedge clock);
               resp_checks++;
               if (cmp_if.cmp_start !== 1'b0) $display("FAIL cmp_start_width: got %b want 0", cmp_if.cmp_start);
               else resp_pass++;
               stable = 1;
               for (int k = 1; k < d; k++) begin
                  @(negedge clock);
                  if (cmp_if.cmp_secret !== sec || cmp_if.cmp_guess !== gss) stable = 0;
               end
               resp_checks++;
               if (!stable) $display("FAIL cmp_hold: got 0 want 1");
               else resp_pass++;
               score(sec, gss, b, c);
               cmp_if.cmp_bulls = b;
               cmp_if.cmp_cows  = c;
               cmp_if.cmp_done  = 1'b1;
               @(negedge clock);
               cmp_if.cmp_done  = 1'b0;
            end
         end
         inj_prev = inj_req;
      end
   end

   // driver tasks
   task automatic do_reset();
      CPU_RESETN = 1'b0;
      confirm    = 1'b0;
      repeat (3) @(negedge clock);
      CPU_RESETN = 1'b1;
      exp_q.delete();
      @(negedge clock);
   endtask

   task automatic press(input logic [15:0] v);
      confirm = 1'b0;
      repeat (DEB + 6) @(negedge clock);
      SW      = v;
      confirm = 1'b1;
      repeat (DEB + 6) @(negedge clock);
      confirm = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget, input string nm);
      int n;
      n = 0;
      while (state !== tgt && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_cnt++;
      if (state !== tgt) $display("FAIL %s: got state %0d want %0d", nm, state, tgt);
      else pass_cnt++;
   endtask

   task automatic measure_state(output int n);
      logic [2:0] s;
      s = state;
      n = 0;
      while (state === s && n < 4 * DISP) begin
         n++;
         @(negedge clock);
      end
   endtask

   // tests
   task automatic test_reset();
      CPU_RESETN = 1'b0;
      #1;
      check_cnt++;
      if ({state, bulls, cows, busy, err, winner, round, cmp_if.cmp_start} !== '0)
         $display("FAIL reset_outputs: got %h want 0", {state, bulls, cows, busy, err, winner, round, cmp_if.cmp_start});
      else pass_cnt++;
      do_reset();
      check_cnt++;
      if (state !== 3'd0 || busy !== 1'b0) $display("FAIL reset_release: got %0d/%b want 0/0", state, busy);
      else pass_cnt++;
   endtask

   task automatic test_bounce();
      do_reset();
      SW = 16'h1234;
      for (int i = 0; i < 50; i++) begin
         confirm = (i % 2 == 0);
         repeat (100) @(negedge clock);
      end
      check_cnt++;
      if (state !== 3'd0) $display("FAIL bounce_quiet: got %0d want 0", state);
      else pass_cnt++;
      confirm = 1'b1;
      repeat (DEB + 10) @(negedge clock);
      check_cnt++;
      if (state !== 3'd1) $display("FAIL bounce_press: got %0d want 1", state);
      else pass_cnt++;
      repeat (3 * DEB) @(negedge clock);
      check_cnt++;
      if (state !== 3'd1) $display("FAIL hold_single: got %0d want 1", state);
      else pass_cnt++;
      confirm = 1'b0;
   endtask

   task automatic test_invalid();
      int n;
      do_reset();
      press(16'h1123);
      check_cnt++;
      if (err !== 1'b1 || state !== 3'd0) $display("FAIL invalid_dup: got err=%b st=%0d want 1/0", err, state);
      else pass_cnt++;
      n = 0;
      while (err === 1'b1 && n < 2 * ERRC) begin
         @(negedge clock);
         n++;
      end
      check_cnt++;
      if (n < ERRC - 4 || n > ERRC) $display("FAIL err_length: got %0d want %0d..%0d", n, ERRC - 4, ERRC);
      else pass_cnt++;
      press(16'h12A4);
      check_cnt++;
      if (err !== 1'b1 || state !== 3'd0) $display("FAIL invalid_bcd: got err=%b st=%0d want 1/0", err, state);
      else pass_cnt++;
      m_s1 = 16'h1234;
      press(m_s1);
      check_cnt++;
      if (err !== 1'b0 || state !== 3'd1) $display("FAIL valid_clears_err: got err=%b st=%0d want 0/1", err, state);
      else pass_cnt++;
   endtask

   task automatic test_guess();
      int n;
      logic [2:0] b, c;
      m_s2 = 16'h5678;
      press(m_s2);
      check_cnt++;
      if (state !== 3'd2) $display("FAIL secret2_latch: got %0d want 2", state);
      else pass_cnt++;
      exp_q.push_back({m_s2, 16'h5687});
      press(16'h5687);
      check_cnt++;
      if (busy !== 1'b1 || state !== 3'd2) $display("FAIL guess_busy: got %b/%0d want 1/2", busy, state);
      else pass_cnt++;
      wait_state(3'd4, 100, "result_j1");
      score(m_s2, 16'h5687, b, c);
      check_cnt++;
      if (bulls !== b || cows !== c || busy !== 1'b0)
         $display("FAIL result_counts: got %0d/%0d busy=%b want %0d/%0d busy=0", bulls, cows, busy, b, c);
      else pass_cnt++;
      measure_state(n);
      check_cnt++;
      if (n != DISP || state !== 3'd3) $display("FAIL result_hold: got %0d cycles st=%0d want %0d st=3", n, state, DISP);
      else pass_cnt++;
   endtask

   task automatic test_win();
      int n, s;
      exp_q.push_back({m_s1, 16'h1234});
      press(16'h1234);
      wait_state(3'd6, 100, "win_enter");
      check_cnt++;
      if (winner !== 1'b1 || bulls !== 3'd4 || cows !== 3'd0 || round !== 4'd0)
         $display("FAIL win_flags: got w=%b %0d/%0d r=%0d want 1 4/0 r=0", winner, bulls, cows, round);
      else pass_cnt++;
      measure_state(n);
      check_cnt++;
      if (n != DISP || state !== 3'd7) $display("FAIL win_hold: got %0d cycles st=%0d want %0d st=7", n, state, DISP);
      else pass_cnt++;
      s = start_cnt;
      press(16'h1357);
      repeat (50) @(negedge clock);
      check_cnt++;
      if (state !== 3'd7 || start_cnt != s || bulls !== 3'd4)
         $display("FAIL fim_absorb: got st=%0d starts=%0d b=%0d want 7 %0d 4", state, start_cnt, bulls, s);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_compare();
      logic [15:0] g;
      do_reset();
      m_s1 = rand_valid();
      m_s2 = rand_valid();
      press(m_s1);
      press(m_s2);
      resp_en = 1'b0;
      g = rand_valid();
      press(g);
      check_cnt++;
      if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy);
      else pass_cnt++;
      CPU_RESETN = 1'b0;
      #1;
      check_cnt++;
      if (state !== 3'd0 || busy !== 1'b0 || bulls !== 3'd0 || cmp_if.cmp_start !== 1'b0)
         $display("FAIL mid_reset: got st=%0d busy=%b b=%0d want 0/0/0", state, busy, bulls);
      else pass_cnt++;
      repeat (3) @(negedge clock);
      CPU_RESETN = 1'b1;
      inj_req = 1'b1;
      repeat (3) @(negedge clock);
      inj_req = 1'b0;
      repeat (10) @(negedge clock);
      check_cnt++;
      if (state !== 3'd0 || busy !== 1'b0 || bulls !== 3'd0)
         $display("FAIL late_done: got st=%0d busy=%b b=%0d want 0/0/0", state, busy, bulls);
      else pass_cnt++;
      exp_q.delete();
      resp_en = 1'b1;
   endtask

   task automatic test_rounds();
      logic [15:0] g;
      logic [2:0]  b, c;
      do_reset();
      m_s1 = rand_valid();
      m_s2 = rand_valid();
      press(m_s1);
      press(m_s2);
      for (int r = 0; r < MAXR; r++) begin
         do g = rand_valid(); while (g == m_s2);
         exp_q.push_back({m_s2, g});
         press(g);
         wait_state(3'd4, 100, "round_result_j1");
         score(m_s2, g, b, c);
         check_cnt++;
         if (bulls !== b || cows !== c) $display("FAIL j1_counts: got %0d/%0d want %0d/%0d", bulls, cows, b, c);
         else pass_cnt++;
         wait_state(3'd3, DISP + 20, "round_guess_j2");
         do g = rand_valid(); while (g == m_s1);
         exp_q.push_back({m_s1, g});
         press(g);
         wait_state(3'd5, 100, "round_result_j2");
         score(m_s1, g, b, c);
         check_cnt++;
         if (bulls !== b || cows !== c || round !== 4'(r))
            $display("FAIL j2_counts: got %0d/%0d r=%0d want %0d/%0d r=%0d", bulls, cows, round, b, c, r);
         else pass_cnt++;
         if (r == MAXR - 1) begin
            inj_req = 1'b1;
            repeat (3) @(negedge clock);
            inj_req = 1'b0;
            check_cnt++;
            if (state !== 3'd5 || bulls !== b) $display("FAIL spurious_done: got st=%0d b=%0d want 5/%0d", state, bulls, b);
            else pass_cnt++;
         end
         wait_state((r == MAXR - 1) ? 3'd7 : 3'd2, DISP + 20, "round_advance");
         check_cnt++;
         if (round !== 4'(r + 1)) $display("FAIL round_count: got %0d want %0d", round, r + 1);
         else pass_cnt++;
      end
      check_cnt++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      else pass_cnt++;
   endtask

   initial begin
      CPU_RESETN = 1'b0;
      confirm    = 1'b0;
      SW         = 16'h0000;
      test_reset();
      test_bounce();
      test_invalid();
      test_guess();
      test_win();
      test_reset_mid_compare();
      test_rounds();
      repeat (5) @(negedge clock);
      $display("%0d/%0d checks passed", pass_cnt + resp_pass, check_cnt + resp_checks);
      $finish;
   end

endmodule
